con_event_queue: RTL
====================

CON_EVENT_QUEUE -- requirements
Module: con_event_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; power of two, minimum 2.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 con_state  input  16  raw button state from snes_controller, treated as arbitrary per-cycle data.
REQ-005 flush  input  1  synchronous clear of FIFO contents.
REQ-006 rd_en  input  1  consumer pop request.
REQ-007 evt_valid  output  1  FIFO non-empty; evt_data valid.
REQ-008 evt_data  output  5  head event: bit 4 = new bit value, bits 3:0 = button index.
REQ-009 evt_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-010 scanning  output  1  high while FSM is in SCAN.

Function
REQ-011 Block SHALL hold a 16-bit prev_state register: last value reported per button.
REQ-012 FSM SHALL have states IDLE and SCAN plus a 4-bit index idx.
REQ-013 IDLE: if con_state != prev_state, next state is SCAN with idx=0; otherwise stay in IDLE.
REQ-014 SCAN, bit equal (con_state[idx]==prev_state[idx]): idx increments, no push.
REQ-015 SCAN, bit differs and FIFO not full: push {con_state[idx], idx}, set prev_state[idx]=con_state[idx], increment idx.
REQ-016 SCAN, bit differs and FIFO full: stall; idx, prev_state and FIFO are unchanged; retry next cycle.
REQ-017 SCAN at idx=15 when the bit is resolved (equal or pushed): return to IDLE and set idx to 0; no wrap within SCAN.
REQ-018 Change on an already-scanned bit during SCAN SHALL be reported via IDLE compare after the scan completes.
REQ-019 Change on a not-yet-scanned bit during SCAN SHALL be reported in the current scan, using the con_state sampled at that cycle.
REQ-020 Events within one scan SHALL enter the FIFO in ascending index order.
REQ-021 FIFO SHALL be first-word-fall-through: evt_valid = occupancy>0; evt_data = head entry combinationally from storage.
REQ-022 Pop occurs when rd_en && evt_valid; rd_en while empty is ignored.
REQ-023 Full test uses the registered occupancy; a same-cycle pop does not enable a push into a full FIFO.
REQ-024 Simultaneous push and pop with 0<count<DEPTH: count unchanged, both take effect.
REQ-025 Scan-to-output latency: a pushed event is visible on evt_valid/evt_data the cycle after the push.
REQ-026 flush empties the FIFO and overrides push/pop that cycle; FSM and prev_state are unaffected.
REQ-027 Pointers SHALL wrap modulo DEPTH; evt_count never exceeds DEPTH.

Reset
REQ-028 On reset assertion all of the following SHALL take their reset values immediately: state=IDLE, idx=0, prev_state=16'h0000, FIFO empty, evt_valid=0, evt_count=0, scanning=0, evt_data=5'h00.
REQ-029 Reset mid-scan discards all queued and pending events.

Structure
REQ-030 Shared package con_pkg SHALL hold the event typedef (value bit, 4-bit index), the scan-state enum, and named SNES button index constants (B=0 ... R=11).
REQ-031 FIFO storage and pointers SHALL be a single sub-module, event_fifo, parameterised by DEPTH and width.

Verification
REQ-032 Single change: con_state 0000->0001 -> one event 5'h10, evt_count=1, scan returns to IDLE within 17 cycles.
REQ-033 Multi-bit change: con_state 0000->8005 -> events 10,12,1F in order; prev_state=8005.
REQ-034 Overflow stall: DEPTH=8, con_state 0000->FFFF, no pops -> 8 events (idx 0-7), scanning stays high; pop 8 -> remaining 8 events (idx 8-15) arrive; FIFO never exceeds 8.
REQ-035 Change during scan: con_state 0000->8001, then bit 0 back to 0 at idx=5 -> events 10,1F,00.
REQ-036 Flush/pop corner: full FIFO + flush + rd_en same cycle -> count=0 next cycle; rd_en while empty leaves count=0.
REQ-037 Reset mid-scan with 3 events queued -> evt_valid=0 immediately; FSM IDLE; nonzero con_state rescanned after release.

Source files
------------

// File: rtl/con_pkg.sv
// Shared types for the controller event queue:
// event bundle, scan FSM states and SNES button indices.
package con_pkg;

  typedef struct packed {
    logic       val;
    logic [3:0] idx;
  } evt_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  localparam int EVT_W = $bits(evt_t);

  localparam logic [3:0] LAST_IDX = 4'd15;

  localparam logic [3:0] BTN_B      = 4'd0;
  localparam logic [3:0] BTN_Y      = 4'd1;
  localparam logic [3:0] BTN_SELECT = 4'd2;
  localparam logic [3:0] BTN_START  = 4'd3;
  localparam logic [3:0] BTN_UP     = 4'd4;
  localparam logic [3:0] BTN_DOWN   = 4'd5;
  localparam logic [3:0] BTN_LEFT   = 4'd6;
  localparam logic [3:0] BTN_RIGHT  = 4'd7;
  localparam logic [3:0] BTN_A      = 4'd8;
  localparam logic [3:0] BTN_X      = 4'd9;
  localparam logic [3:0] BTN_L      = 4'd10;
  localparam logic [3:0] BTN_R      = 4'd11;

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO with occupancy count;
// flush clears contents and wins over push/pop.
module event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;

  // Gate the head so an empty FIFO never shows stale storage
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push)
                         - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/con_event_queue.sv
// Turns controller state changes into per-button events,
// scanning bits in ascending order into a FWFT queue.
module con_event_queue
  import con_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [15:0]            con_state,
  input  logic                   flush,
  input  logic                   rd_en,
  output logic                   evt_valid,
  output logic [4:0]             evt_data,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   scanning
);

  scan_state_e state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] prev_q, prev_d;
  logic        push;
  logic        fifo_full;
  logic        bit_diff;
  evt_t        push_evt;

  assign bit_diff = con_state[idx_q] != prev_q[idx_q];
  assign push_evt = '{val: con_state[idx_q], idx: idx_q};
  assign scanning = (state_q == SCAN);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prev_d  = prev_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (con_state != prev_q) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        // A differing bit holds the scan until the FIFO has room
        if (!bit_diff || !fifo_full) begin
          if (bit_diff) begin
            push          = 1'b1;
            prev_d[idx_q] = con_state[idx_q];
          end
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prev_q  <= prev_d;
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (rd_en),
    .wdata_i (push_evt),
    .rdata_o (evt_data),
    .valid_o (evt_valid),
    .full_o  (fifo_full),
    .count_o (evt_count)
  );

endmodule
